// File: rtl/corr_window_engine_pkg.sv
// Shared constants and FSM encoding for the template-vs-frame correlation worker.
package corr_window_engine_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int TPL_W_DEF = 16;
  localparam int TPL_H_DEF = 16;
  localparam int PIX_W_DEF = 8;

  localparam int COORD_W  = 13;
  localparam int FRAME_AW = 20;
  localparam int TPL_AW   = 10;
  localparam int ACC_W    = 32;
  localparam int TAP_W    = 5;
  localparam int CNT_W    = 2;

  localparam int DRAIN_CYCLES  = 3;
  localparam int DONE_CYCLES   = 2;
  localparam int SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/corr_mac.sv
// Multiply-accumulate pipeline: aligns the tap valid with returning pixel data,
// registers the product, then adds it into a saturating 32-bit accumulator.
module corr_mac
  import corr_window_engine_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [PIX_W-1:0]  a,
  input  logic [PIX_W-1:0]  b,
  output logic [ACC_W-1:0]  acc
);

  logic                 data_vld_q, data_vld_d;
  logic                 prod_vld_q, prod_vld_d;
  logic [2*PIX_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [2*PIX_W-1:0]   a_ext, b_ext;
  logic [ACC_W:0]       sum;

  always_comb begin
    a_ext      = {{PIX_W{1'b0}}, a};
    b_ext      = {{PIX_W{1'b0}}, b};
    data_vld_d = valid;
    prod_vld_d = data_vld_q;
    prod_d     = data_vld_q ? a_ext * b_ext : '0;
    sum        = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    acc_d      = acc_q;
    // The carry out of the 33-bit sum means the score has hit the ceiling.
    if (prod_vld_q) acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    if (clear) begin
      data_vld_d = 1'b0;
      prod_vld_d = 1'b0;
      prod_d     = '0;
      acc_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      data_vld_q <= data_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/corr_window_engine.sv
// Correlation worker: walks a TPL_W x TPL_H window at the controller's (X,Y),
// streams frame/template reads into corr_mac and hands back the score with a 2-cycle strobe.
module corr_window_engine
  import corr_window_engine_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int TPL_W = TPL_W_DEF,
  parameter int TPL_H = TPL_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iFrameDone,
  input  logic                iScanDone,
  input  logic [COORD_W-1:0]  iX,
  input  logic [COORD_W-1:0]  iY,
  output logic [FRAME_AW-1:0] oFrameAddr,
  input  logic [PIX_W-1:0]    iFramePix,
  output logic [TPL_AW-1:0]   oTplAddr,
  input  logic [PIX_W-1:0]    iTplPix,
  output logic                oCorrFinished,
  output logic [ACC_W-1:0]    oCurrentCorr,
  output logic                oBusy
);

  state_t                state_q, state_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [TAP_W-1:0]      tx_q, tx_d, ty_q, ty_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_AW-1:0]   frame_addr_q, frame_addr_d;
  logic [TPL_AW-1:0]     tpl_addr_q, tpl_addr_d;
  logic                  tap_vld_q, tap_vld_d;
  logic                  finished_q, finished_d;
  logic [ACC_W-1:0]      corr_q, corr_d;
  logic                  busy_q, busy_d;

  logic                  mac_clear;
  logic [ACC_W-1:0]      acc;
  logic                  load_tap;
  logic                  last_tap;
  logic [COORD_W-1:0]    base_x, base_y;
  logic [TAP_W-1:0]      next_tx, next_ty;
  logic [COORD_W:0]      col, row;
  logic                  tap_in_range;

  assign last_tap = (tx_q == TAP_W'(TPL_W-1)) && (ty_q == TAP_W'(TPL_H-1));

  // NOTE: every signal driven here gets a default on entry, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    cnt_d        = cnt_q;
    frame_addr_d = frame_addr_q;
    tpl_addr_d   = tpl_addr_q;
    tap_vld_d    = 1'b0;
    finished_d   = 1'b0;
    corr_d       = corr_q;
    busy_d       = busy_q;
    mac_clear    = 1'b0;
    load_tap     = 1'b0;
    base_x       = x_q;
    base_y       = y_q;
    next_tx      = tx_q;
    next_ty      = ty_q;

    case (state_q)
      ST_IDLE: begin
        if (iFrameDone && !iScanDone) begin
          // Tap 0 is addressed straight from the live coordinate so it issues
          // in the first ISSUE cycle.
          state_d   = ST_ISSUE;
          x_d       = iX;
          y_d       = iY;
          base_x    = iX;
          base_y    = iY;
          next_tx   = '0;
          next_ty   = '0;
          load_tap  = 1'b1;
          mac_clear = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!iFrameDone) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (last_tap) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          if (tx_q == TAP_W'(TPL_W-1)) begin
            next_tx = '0;
            next_ty = ty_q + 1'b1;
          end else begin
            next_tx = tx_q + 1'b1;
          end
          load_tap = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!iFrameDone) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(DRAIN_CYCLES-1)) begin
          state_d    = ST_DONE;
          cnt_d      = '0;
          corr_d     = acc;
          finished_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (cnt_q == CNT_W'(DONE_CYCLES-1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          finished_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    col          = {1'b0, base_x} + (COORD_W+1)'(next_tx);
    row          = {1'b0, base_y} + (COORD_W+1)'(next_ty);
    tap_in_range = (col < (COORD_W+1)'(H_RES)) && (row < (COORD_W+1)'(V_RES));

    if (load_tap) begin
      tx_d       = next_tx;
      ty_d       = next_ty;
      tpl_addr_d = TPL_AW'(next_ty) * TPL_AW'(TPL_W) + TPL_AW'(next_tx);
      tap_vld_d  = tap_in_range;
      // Clipped taps keep the previous legal address on the SRAM bus.
      if (tap_in_range)
        frame_addr_d = FRAME_AW'(row) * FRAME_AW'(H_RES) + FRAME_AW'(col);
    end
  end

  // NOTE: registers update with non-blocking assignments only, and reset is
  // synchronous so it simply takes priority inside the clocked block.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      cnt_q        <= '0;
      frame_addr_q <= '0;
      tpl_addr_q   <= '0;
      tap_vld_q    <= 1'b0;
      finished_q   <= 1'b0;
      corr_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      cnt_q        <= cnt_d;
      frame_addr_q <= frame_addr_d;
      tpl_addr_q   <= tpl_addr_d;
      tap_vld_q    <= tap_vld_d;
      finished_q   <= finished_d;
      corr_q       <= corr_d;
      busy_q       <= busy_d;
    end
  end

  corr_mac #(.PIX_W(PIX_W)) u_mac (
    .clk   (iCLK),
    .rst   (iRST),
    .clear (mac_clear),
    .valid (tap_vld_q),
    .a     (iFramePix),
    .b     (iTplPix),
    .acc   (acc)
  );

  assign oFrameAddr    = frame_addr_q;
  assign oTplAddr      = tpl_addr_q;
  assign oCorrFinished = finished_q;
  assign oCurrentCorr  = corr_q;
  assign oBusy         = busy_q;

endmodule
